// File: rtl/cache_sequencer_pkg.sv
// Shared command payload types for the cache trace sequencer.
// Provides the address layout (tag / index / offset), the command struct
// presented on cmd / lookup_cmd, and the command opcode values.
package cache_sequencer_pkg;

  localparam int unsigned TAG_W    = 12;
  localparam int unsigned INDEX_W  = 14;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned N_W      = 4;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } address_t;

  typedef struct packed {
    logic [N_W-1:0] n;
    address_t       address;
  } command_t;

  // Trace opcodes; every other value is a malformed command.
  localparam logic [N_W-1:0] CMD_READ   = N_W'(0);
  localparam logic [N_W-1:0] CMD_WRITE  = N_W'(1);
  localparam logic [N_W-1:0] CMD_IFETCH = N_W'(2);
  localparam logic [N_W-1:0] CMD_INVAL  = N_W'(3);
  localparam logic [N_W-1:0] CMD_SNOOP  = N_W'(4);
  localparam logic [N_W-1:0] CMD_CLEAR  = N_W'(8);
  localparam logic [N_W-1:0] CMD_DUMP   = N_W'(9);

endpackage

// File: rtl/cache_sequencer.sv
// Cache trace sequencer: accepts one trace command at a time and steps the
// cache arrays through read / lookup / write-back, a full-array clear, or a
// full-array dump, while keeping saturating access statistics.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid, cmd           offered trace command
//   cmd_ready                command can be accepted (IDLE only)
//   set_index                set address to the cache arrays
//   arr_rd_en                array read strobe (data valid next cycle)
//   arr_wr_en, arr_clear     array write strobe; with arr_clear writes an empty line
//   lookup_valid, lookup_cmd lookup datapath inputs and their qualifier
//   hit_d, hit_i             datapath hit flags, sampled only during lookup
//   dump_valid               array read data for the previous set is to be printed
//   busy                     sequencer is not idle
//   rd/wr/if/hit/miss/bad_cnt saturating statistics counters
module cache_sequencer
  import cache_sequencer_pkg::*;
#(
  parameter int unsigned SET_BITS = 14,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  command_t            cmd,
  output logic                cmd_ready,
  output logic [SET_BITS-1:0] set_index,
  output logic                arr_rd_en,
  output logic                arr_wr_en,
  output logic                arr_clear,
  output logic                lookup_valid,
  output command_t            lookup_cmd,
  input  logic                hit_d,
  input  logic                hit_i,
  output logic                dump_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic [CNT_W-1:0]    if_cnt,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic [CNT_W-1:0]    bad_cnt
);

  localparam logic [SET_BITS-1:0] SET_LAST = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOOKUP,
    WRITE,
    CLEAR,
    DUMP,
    DUMP_TAIL
  } state_t;

  state_t              state, state_d;
  logic [SET_BITS-1:0] set_index_d;
  command_t            lookup_cmd_d;
  logic                cmd_ready_d, busy_d;
  logic                arr_rd_en_d, arr_wr_en_d, arr_clear_d;
  logic                lookup_valid_d, dump_valid_d;
  logic [CNT_W-1:0]    rd_cnt_d, wr_cnt_d, if_cnt_d;
  logic [CNT_W-1:0]    hit_cnt_d, miss_cnt_d, bad_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, datapath and statistics update.
  always_comb begin
    state_d      = state;
    set_index_d  = set_index;
    lookup_cmd_d = lookup_cmd;
    rd_cnt_d     = rd_cnt;
    wr_cnt_d     = wr_cnt;
    if_cnt_d     = if_cnt;
    hit_cnt_d    = hit_cnt;
    miss_cnt_d   = miss_cnt;
    bad_cnt_d    = bad_cnt;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          lookup_cmd_d = cmd;
          set_index_d  = SET_BITS'(cmd.address.index);
          case (cmd.n)
            CMD_READ, CMD_WRITE, CMD_IFETCH, CMD_INVAL, CMD_SNOOP: begin
              state_d = READ;
            end
            CMD_CLEAR: begin
              state_d     = CLEAR;
              set_index_d = '0;
            end
            CMD_DUMP: begin
              state_d     = DUMP;
              set_index_d = '0;
            end
            default: begin
              bad_cnt_d = sat_inc(bad_cnt);
            end
          endcase
        end
      end

      READ: begin
        state_d = LOOKUP;
      end

      // Hit flags are only looked at here, so X elsewhere cannot reach a counter.
      LOOKUP: begin
        state_d = WRITE;
        case (lookup_cmd.n)
          CMD_READ: begin
            rd_cnt_d = sat_inc(rd_cnt);
            if (hit_d) hit_cnt_d  = sat_inc(hit_cnt);
            else       miss_cnt_d = sat_inc(miss_cnt);
          end
          CMD_WRITE: begin
            wr_cnt_d = sat_inc(wr_cnt);
            if (hit_d) hit_cnt_d  = sat_inc(hit_cnt);
            else       miss_cnt_d = sat_inc(miss_cnt);
          end
          CMD_IFETCH: begin
            if_cnt_d = sat_inc(if_cnt);
            if (hit_i) hit_cnt_d  = sat_inc(hit_cnt);
            else       miss_cnt_d = sat_inc(miss_cnt);
          end
          default: begin
          end
        endcase
      end

      WRITE: begin
        state_d = IDLE;
      end

      // Last cleared set also wipes the statistics.
      CLEAR: begin
        if (set_index == SET_LAST) begin
          state_d    = IDLE;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          if_cnt_d   = '0;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
          bad_cnt_d  = '0;
        end else begin
          set_index_d = set_index + SET_BITS'(1);
        end
      end

      DUMP: begin
        if (set_index == SET_LAST) state_d = DUMP_TAIL;
        else                       set_index_d = set_index + SET_BITS'(1);
      end

      DUMP_TAIL: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered, so decode them from the upcoming state.
    cmd_ready_d    = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
    arr_rd_en_d    = (state_d == READ) || (state_d == DUMP);
    arr_wr_en_d    = (state_d == WRITE) || (state_d == CLEAR);
    arr_clear_d    = (state_d == CLEAR);
    lookup_valid_d = (state_d == LOOKUP);
    // Read data appears one cycle after each dump read.
    dump_valid_d   = (state == DUMP);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      set_index    <= '0;
      lookup_cmd   <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      arr_rd_en    <= 1'b0;
      arr_wr_en    <= 1'b0;
      arr_clear    <= 1'b0;
      lookup_valid <= 1'b0;
      dump_valid   <= 1'b0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      if_cnt       <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      bad_cnt      <= '0;
    end else begin
      state        <= state_d;
      set_index    <= set_index_d;
      lookup_cmd   <= lookup_cmd_d;
      cmd_ready    <= cmd_ready_d;
      busy         <= busy_d;
      arr_rd_en    <= arr_rd_en_d;
      arr_wr_en    <= arr_wr_en_d;
      arr_clear    <= arr_clear_d;
      lookup_valid <= lookup_valid_d;
      dump_valid   <= dump_valid_d;
      rd_cnt       <= rd_cnt_d;
      wr_cnt       <= wr_cnt_d;
      if_cnt       <= if_cnt_d;
      hit_cnt      <= hit_cnt_d;
      miss_cnt     <= miss_cnt_d;
      bad_cnt      <= bad_cnt_d;
    end
  end

endmodule

// File: doc/cache_sequencer.md
CACHE_SEQUENCER -- requirements
Module: cache_sequencer

Interface
REQ-001 Parameter SET_BITS, default 14, SHALL set the set-index width (sets = 2**SET_BITS).
REQ-002 Parameter CNT_W, default 32, SHALL set the statistics counter width.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port cmd_valid, input, 1: a trace command is offered.
REQ-006 Port cmd, input, command_t: the offered command (n, address).
REQ-007 Port cmd_ready, output, 1: the sequencer can accept a command.
REQ-008 Port set_index, output, SET_BITS: set address driven to the cache arrays.
REQ-009 Port arr_rd_en, output, 1: array read strobe; read data is valid the following cycle.
REQ-010 Port arr_wr_en, output, 1: array write strobe; writes the lookup datapath's return lines.
REQ-011 Port arr_clear, output, 1: when set together with arr_wr_en, the arrays write the invalid, LRU-zero line instead.
REQ-012 Port lookup_valid, output, 1: the lookup datapath inputs are valid this cycle.
REQ-013 Port lookup_cmd, output, command_t: the registered command presented to the lookup datapath.
REQ-014 Port hit_d, input, 1: data-cache hit reported by the datapath, sampled only while lookup_valid is high.
REQ-015 Port hit_i, input, 1: instruction-cache hit reported by the datapath, sampled only while lookup_valid is high.
REQ-016 Port dump_valid, output, 1: the array read data for set_index_q is to be printed.
REQ-017 Port busy, output, 1: the FSM is not IDLE.
REQ-018 Ports rd_cnt, wr_cnt, if_cnt, hit_cnt, miss_cnt, bad_cnt, output, CNT_W each: statistics counters.

Function
REQ-019 FSM states SHALL be IDLE, READ, LOOKUP, WRITE, CLEAR, DUMP and DUMP_TAIL; cmd_ready SHALL be 1 only in IDLE.
REQ-020 A command SHALL be accepted when cmd_valid and cmd_ready are both 1; it is registered as lookup_cmd, and set_index is latched from cmd.address.index.
REQ-021 For n in {0,1,2,3,4} the state sequence SHALL be IDLE->READ->LOOKUP->WRITE->IDLE, one cycle each.
  - arr_rd_en=1 only in READ.
  - lookup_valid=1 only in LOOKUP.
  - arr_wr_en=1, arr_clear=0 only in WRITE.
  - cmd_ready returns 4 cycles after acceptance.
REQ-022 In LOOKUP, statistics SHALL update as follows:
  - n=0: increment rd_cnt.
  - n=1: increment wr_cnt.
  - n=2: increment if_cnt.
  - n=0/1: increment hit_cnt if hit_d, else miss_cnt.
  - n=2: increment hit_cnt if hit_i, else miss_cnt.
  - n=3/4: leave the statistics unchanged.
REQ-023 For n=8, the sequencer SHALL go IDLE->CLEAR and sweep set_index from 0 to 2**SET_BITS-1, one set per cycle, with arr_wr_en=arr_clear=1.
  - Return to IDLE after the last set.
  - On the final cycle, zero all six counters.
REQ-024 For n=9, the sequencer SHALL go IDLE->DUMP and sweep set_index from 0 to 2**SET_BITS-1 with arr_rd_en=1.
  - dump_valid SHALL be high one cycle after each read.
  - DUMP_TAIL supplies the final dump_valid, then the FSM returns to IDLE.
  - Statistics are unchanged.
REQ-025 Any other n SHALL be accepted and discarded: bad_cnt increments, the FSM stays in IDLE, and cmd_ready stays 1.
REQ-026 Set-index sweeps SHALL not wrap: the counter stops at 2**SET_BITS-1.
REQ-027 All counters SHALL saturate at 2**CNT_W-1.
REQ-028 Outside their named states, arr_rd_en, arr_wr_en, arr_clear, lookup_valid and dump_valid SHALL be 0.
REQ-029 hit_d and hit_i SHALL be ignored outside LOOKUP; X on them outside LOOKUP SHALL not propagate to any counter.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE, and set_index, lookup_cmd and all counters SHALL be 0.
REQ-031 While rst=1, all strobes SHALL be 0, busy=0 and cmd_ready=0; cmd_ready=1 from the first clock edge after deassertion.
REQ-032 Reset asserted mid-command or mid-sweep SHALL abort immediately with no further array write; the aborted command is not retried.

Verification
REQ-033 Read hit: n=0, address index 5, hit_d=1 in LOOKUP -> set_index=5, arr_rd_en at cycle 1, lookup_valid at cycle 2, arr_wr_en at cycle 3, rd_cnt=1, hit_cnt=1, cmd_ready high at cycle 4.
REQ-034 Misses and held valid: n=1 (hit_d=0), then n=2 (hit_i=0) with cmd_valid held high -> wr_cnt=1, if_cnt=1, miss_cnt=2, second acceptance exactly 4 cycles after the first.
REQ-035 Clear: SET_BITS=2, counters nonzero, n=8 -> 4 cycles of arr_wr_en=arr_clear=1 with set_index 0,1,2,3, then all counters 0 and IDLE.
REQ-036 Dump: SET_BITS=2, n=9 -> arr_rd_en on sets 0..3, dump_valid on the 4 following cycles, counters unchanged.
REQ-037 Bad command and invalidate: n=6 -> bad_cnt=1, no strobes; n=3 -> full READ/LOOKUP/WRITE sequence, hit and miss counters unchanged.
REQ-038 Reset mid-sweep: rst=1 during CLEAR at set_index=2 -> strobes drop asynchronously, IDLE after reset, no arr_wr_en to set 3.
